// File: rtl/dither_dac_spi_if.sv
// Serial DAC pins driven by dither_dac_spi.
// Master drives SPI mode 0; slave is the DAC side.
interface dither_dac_spi_if;
    logic sclk;
    logic cs_n;
    logic mosi;

    modport master (output sclk, output cs_n, output mosi);
    modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/dither_dac_spi.sv
// Dither DAC writer: bias-adds, saturates and offset-binary encodes
// the dither level, then sends {cmd, code} over SPI mode 0.
module dither_dac_spi #(
    parameter int                  DAC_BITS = 16,
    parameter int                  CMD_BITS = 8,
    parameter logic [CMD_BITS-1:0] DAC_CMD  = 8'h30,
    parameter int                  SCLK_DIV = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic signed [31:0]   i_dither_out,
    input  logic signed [31:0]   i_bias,
    input  logic [31:0]          i_update_period,
    dither_dac_spi_if.master     spi,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DAC_BITS-1:0]  o_code,
    output logic                 o_sat
);
    localparam int FW = CMD_BITS + DAC_BITS;
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(FW + 1);
    localparam logic signed [32:0] MAXV = (33'sd1 <<< (DAC_BITS - 1)) - 33'sd1;
    localparam logic signed [32:0] MINV = -(33'sd1 <<< (DAC_BITS - 1));
    localparam logic [DAC_BITS-1:0] MSB = {1'b1, {(DAC_BITS - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                req_q, req_d;
    logic [DW-1:0]       div_q, div_d;
    logic                phase_q, phase_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [FW-1:0]       sh_q, sh_d;
    logic [DAC_BITS-1:0] code_q, code_d;
    logic                sat_q, sat_d;

    logic                cnt_zero, req_now, div_end, last_bit, start;
    logic signed [32:0]  sum, clp;
    logic                clamp;
    logic [DAC_BITS-1:0] code_new;

    assign cnt_zero = (cnt_q == 32'd0);
    assign req_now  = req_q | cnt_zero;
    assign div_end  = (div_q == DW'(SCLK_DIV - 1));
    assign last_bit = (bit_q == BW'(FW - 1));
    // A request seen on the done cycle chains straight into the next LOAD.
    assign start    = req_now && i_en &&
                      (state_q == S_IDLE || (state_q == S_GAP && div_end));

    always_comb begin
        sum      = {i_dither_out[31], i_dither_out} + {i_bias[31], i_bias};
        clamp    = (sum > MAXV) || (sum < MINV);
        clp      = (sum > MAXV) ? MAXV : ((sum < MINV) ? MINV : sum);
        code_new = DAC_BITS'(clp) ^ MSB;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            code_q  <= MSB;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            code_q  <= code_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? i_update_period : cnt_q - 32'd1;
        req_d   = start ? 1'b0 : (cnt_zero ? 1'b1 : req_q);
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = bit_q;
        sh_d    = sh_q;
        code_d  = code_q;
        sat_d   = sat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                code_d  = code_new;
                sat_d   = clamp;
                sh_d    = {DAC_CMD, code_new};
                bit_d   = '0;
            end
            S_SHIFT: begin
                div_d   = div_end ? '0 : div_q + DW'(1);
                phase_d = div_end ? ~phase_q : phase_q;
                // Shift at the end of the high phase so MOSI moves as SCLK falls.
                if (div_end && phase_q) begin
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + BW'(1);
                    if (last_bit) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) state_d = S_GAP;
            end
            S_GAP: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) state_d = start ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state_q != S_IDLE);
        o_done   = (state_q == S_GAP) && div_end;
        o_code   = code_q;
        o_sat    = sat_q;
        spi.cs_n = !(state_q == S_SHIFT || state_q == S_HOLD);
        spi.sclk = (state_q == S_SHIFT) && phase_q;
        spi.mosi = (state_q == S_SHIFT) && sh_q[FW-1];
    end
endmodule

// File: tb/tb_dither_dac_spi.sv
// Self-checking bench for dither_dac_spi: directed and random frames
// against an arithmetic reference model, plus pacing/enable/reset cases.
module tb_dither_dac_spi;
    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic signed [31:0] dither, bias;
    logic [31:0]       period;
    logic              busy, done, sat;
    logic [15:0]       code;

    dither_dac_spi_if spi ();

    dither_dac_spi dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_en            (en),
        .i_dither_out    (dither),
        .i_bias          (bias),
        .i_update_period (period),
        .spi             (spi),
        .o_busy          (busy),
        .o_done          (done),
        .o_code          (code),
        .o_sat           (sat)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] cap = '0;
    int          nbits = 0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;

    // DAC-side capture: new frame on CS falling, bit on each SCLK rise.
    always @(negedge clk) begin
        if (spi.cs_n === 1'b0 && cs_prev === 1'b1) begin
            nbits = 0;
            cap   = '0;
        end
        if (spi.cs_n === 1'b0 && spi.sclk === 1'b1 && sclk_prev === 1'b0) begin
            cap   = {cap[62:0], spi.mosi};
            nbits = nbits + 1;
        end
        cs_prev   = spi.cs_n;
        sclk_prev = spi.sclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int d, input int b,
                         output logic [15:0] c, output logic s);
        longint v;
        v = longint'(d) + longint'(b);
        if (v > 32767) begin
            c = 16'hFFFF; s = 1'b1;
        end else if (v < -32768) begin
            c = 16'h0000; s = 1'b1;
        end else begin
            c = 16'(v + 32768); s = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit, output int n, output int lowc);
        n = 0;
        lowc = 0;
        do begin
            @(negedge clk);
            n++;
            if (spi.cs_n === 1'b0) lowc++;
        end while (done !== 1'b1 && n < limit);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic reset_release(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_frame(input string tag, input int d, input int b);
        logic [15:0] ec;
        logic        es;
        int          n, lowc;
        dither = d;
        bias   = b;
        period = 32'd1000;
        en     = 1'b1;
        reset_release(2);
        wait_done(400, n, lowc);
        model(d, b, ec, es);
        chk({tag, "_code"}, 64'(code), 64'(ec));
        chk({tag, "_sat"}, 64'(sat), 64'(es));
        chk({tag, "_nbits"}, 64'(nbits), 64'd24);
        chk({tag, "_word"}, 64'(cap[23:0]), 64'({8'h30, ec}));
        chk({tag, "_len"}, 64'(n), 64'd201);
        chk({tag, "_cslow"}, 64'(lowc), 64'd196);
    endtask

    initial begin
        int n, lowc, n10, dcount;
        int v1, v2;
        logic [15:0] ec;
        logic        es;

        rst    = 1'b1;
        en     = 1'b0;
        dither = 0;
        bias   = 0;
        period = 32'd1000;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(spi.cs_n), 64'd1);
        chk("rst_sclk", 64'(spi.sclk), 64'd0);
        chk("rst_mosi", 64'(spi.mosi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_code", 64'(code), 64'h8000);
        chk("rst_sat", 64'(sat), 64'd0);

        dither = 20;
        en     = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("first_load_busy", 64'(busy), 64'd1);
        chk("first_load_cs", 64'(spi.cs_n), 64'd1);
        @(negedge clk);
        chk("first_shift_cs", 64'(spi.cs_n), 64'd0);
        wait_done(400, n, lowc);
        chk("first_len", 64'(n + 2), 64'd201);
        chk("first_cslow", 64'(lowc + 1), 64'd196);
        chk("first_word", 64'(cap[23:0]), 64'h308014);

        do_frame("pos20", 20, 0);
        do_frame("neg20", -20, 0);
        do_frame("biasmin", 0, -32768);
        do_frame("sat_hi", 40000, 0);
        do_frame("sat_lo", -40000, 0);
        do_frame("nowrap", 32'h7FFFFFFF, 1);
        for (int i = 0; i < 4; i++)
            do_frame("rnd_small", int'($urandom_range(0, 90000)) - 45000,
                     int'($urandom_range(0, 20000)) - 10000);
        for (int i = 0; i < 3; i++)
            do_frame("rnd_wide", int'($urandom), int'($urandom));

        // Back-to-back frames; input change mid-frame lands in the next frame.
        period = 32'd0;
        v1 = int'($urandom_range(0, 60000)) - 30000;
        dither = v1;
        bias   = 0;
        reset_release(2);
        wait_done(400, n, lowc);
        for (int k = 0; k < 2; k++) begin
            v2 = int'($urandom_range(0, 60000)) - 30000;
            n10 = 0;
            repeat (10) begin
                @(negedge clk);
                n10++;
            end
            dither = v2;
            wait_done(400, n, lowc);
            chk("p0_spacing", 64'(n10 + n), 64'd201);
            model(v1, 0, ec, es);
            chk("p0_code_inflight", 64'(code), 64'(ec));
            v1 = v2;
        end

        period = 32'd50;
        reset_release(2);
        wait_done(400, n, lowc);
        for (int k = 0; k < 3; k++) begin
            wait_done(400, n, lowc);
            chk("p50_spacing", 64'(n), 64'd201);
        end

        // Enable dropped mid-frame.
        period = 32'd1000;
        dither = 1234;
        bias   = -34;
        reset_release(2);
        n = 0;
        while (!(spi.cs_n === 1'b0 && nbits == 10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("en_reach_bit10", 64'(nbits), 64'd10);
        en = 1'b0;
        wait_done(400, n, lowc);
        model(1234, -34, ec, es);
        chk("en_off_nbits", 64'(nbits), 64'd24);
        chk("en_off_word", 64'(cap[23:0]), 64'({8'h30, ec}));
        dcount = 0;
        repeat (5000) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        chk("en_off_idle", 64'(dcount), 64'd0);
        dither = -777;
        en = 1'b1;
        @(negedge clk);
        chk("en_on_load", 64'(busy), 64'd1);
        chk("en_on_load_cs", 64'(spi.cs_n), 64'd1);
        wait_done(400, n, lowc);
        model(-777, -34, ec, es);
        chk("en_on_code", 64'(code), 64'(ec));
        chk("en_on_nbits", 64'(nbits), 64'd24);

        // Reset mid-frame.
        dither = 5000;
        bias   = 0;
        reset_release(2);
        n = 0;
        while (!(spi.cs_n === 1'b0 && nbits == 5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_bit5", 64'(nbits), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", 64'(spi.cs_n), 64'd1);
        chk("midrst_sclk", 64'(spi.sclk), 64'd0);
        chk("midrst_mosi", 64'(spi.mosi), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_code", 64'(code), 64'h8000);
        dither = -3000;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_load", 64'(busy), 64'd1);
        wait_done(400, n, lowc);
        model(-3000, 0, ec, es);
        chk("midrst_len", 64'(n + 1), 64'd201);
        chk("midrst_nbits", 64'(nbits), 64'd24);
        chk("midrst_word", 64'(cap[23:0]), 64'({8'h30, ec}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
